cpu_execute_stage: RTL and testbench
====================================

# cpu_execute_stage

Execute stage of the Klara-RV integer pipeline. It sits between decode and memory/writeback: it accepts one decoded instruction per handshake, drives one ALU instance, and resolves branches and jumps. It registers the result, memory request fields and branch redirect for the downstream stage. Shifts optionally take one extra cycle through a registered shifter path.

## Interface
- ALIGN_CHECK, default 1: when 1, a taken branch/jump target with bit 1 set raises o_misaligned instead of o_branch.
- i_clock  in  1  single clock, all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  kill from a later stage (trap); discards held and in-flight work.
- i_valid  in  1  decode presents an instruction.
- o_ready  out  1  stage can accept this cycle.
- i_class  in  4  exec class: ALU, SHIFT, LUI, AUIPC, BRANCH, JAL, JALR, LOAD, STORE.
- i_alu_op  in  5  ALU operation code.
- i_pc, i_rs1, i_rs2, i_imm  in  32 each  instruction PC, operands, sign-extended immediate.
- i_rd  in  5  destination register.
- o_valid  out  1  registered result present.
- i_ready  in  1  downstream accepts.
- o_rd  out  5; o_rd_write  out  1; o_rd_value  out  32  writeback fields.
- o_mem_read, o_mem_write  out  1 each; o_mem_addr, o_mem_wdata  out  32 each.
- o_branch  out  1  one-cycle redirect pulse; o_branch_target  out  32.
- o_misaligned  out  1  one-cycle fault pulse, with o_valid.

## Operation
- ALU operand select: ALU/SHIFT use rs1 and rs2, or rs1 and imm if decode set op2 to imm via i_alu_op. AUIPC uses pc and imm. LOAD/STORE/JALR use rs1 and imm with add. BRANCH uses rs1 and rs2 with a compare op.
- Result selection: ALU uses the ALU result. SHIFT uses the shift result. LUI uses imm. AUIPC uses the signed sum. JAL/JALR use pc+4 from a dedicated adder. LOAD uses the signed sum as o_mem_addr. STORE uses the signed sum as o_mem_addr and rs2 as o_mem_wdata.
- o_rd_write is 1 for every class except BRANCH and STORE. It is forced to 0 when i_rd==0.
- Branch targets: BRANCH and JAL use pc+imm from a dedicated adder. JALR uses (rs1+imm) with bit 0 cleared. The branch is taken when the compare result is 1 (BRANCH) or always (JAL, JALR).
- When a branch is taken and ALIGN_CHECK=1 with target[1]=1: o_misaligned=1, o_branch=0, o_rd_write=0.
- FSM:
  - IDLE: waits for a handshake.
  - SHIFT_WAIT: present only with the macro; captures the shifter output.
  - HOLD: o_valid high, waiting for i_ready.
- Transitions:
  - An accepted non-shift instruction goes to HOLD, or stays in the pass-through path if i_ready is high.
  - An accepted shift goes to SHIFT_WAIT, then to output.

## Timing
- On reset, every output is 0 except o_ready=1, and the state is IDLE.
- Handshake: the input is accepted when i_valid && o_ready. o_ready = (state!=SHIFT_WAIT) && (!o_valid || i_ready). Full throughput is one instruction per cycle.
- Latency:
  - Non-shift: o_valid rises 1 cycle after acceptance.
  - Shift: 2 cycles with CPU_EXECUTE_SHIFT_REG_EN, otherwise 1.
- o_branch and o_misaligned are high only in the first cycle of o_valid for that instruction, never repeated while held.
- While o_valid && !i_ready, all outputs are stable.
- i_flush has priority over everything. Next cycle: o_valid=0, state IDLE, and no acceptance in the flush cycle even if i_valid=1.
- i_reset mid-shift: the instruction is discarded and the reset values apply next cycle.
- All arithmetic is 32-bit modulo: pc+4 and pc+imm wrap, and 0xFFFFFFFC+4 gives 0.

## Configuration
- CPU_EXECUTE_SHIFT_REG_EN defined: shift class passes through SHIFT_WAIT and its result is taken from a register on the ALU shift output. Latency is 2 and o_ready is low for one cycle.
- Undefined: SHIFT_WAIT is not synthesized and shifts behave like ALU ops with latency 1.

## Structure
- Shared package (CPU_Defines): the exec class enum values, the FSM state encoding, and the ALU op codes already defined there.
- One sub-module: a single CPU_ALU instance. The pc+4 and branch-target adders stay in this block.

## Test plan
- ALU add, rs1=5, imm=7, rd=3, i_ready=1: o_rd_value=12, o_rd_write=1, o_valid one cycle after acceptance, back-to-back acceptance each cycle.
- BEQ, rs1=rs2=9, pc=0x100, imm=0x20: o_branch pulse with o_branch_target=0x120, o_rd_write=0. With rs2=8: o_branch=0.
- JALR, rs1=0x1001, imm=1, ALIGN_CHECK=1: target 0x1002, o_misaligned=1, o_branch=0. JAL at pc=0xFFFFFFFC: o_rd_value=0.
- SLL of 1 by 31 with macro defined: o_ready=0 for one cycle, result 0x80000000 two cycles after acceptance. Without macro: one cycle.
- STORE with i_ready=0 for 3 cycles: outputs stable, o_ready=0, o_mem_addr=rs1+imm. Releases on i_ready.
- i_flush and i_valid together while holding: next cycle o_valid=0, and the input is not accepted.

Source files
------------

// File: rtl/cpu_execute_stage_pkg.sv
// Shared definitions for the Klara-RV execute stage: exec classes, ALU function codes, FSM states.
// The ALU op field is {use_imm, fn[3:0]}; bit 4 selects the immediate as the second operand.
package cpu_execute_stage_pkg;

  typedef enum logic [3:0] {
    CLS_ALU    = 4'd0,
    CLS_SHIFT  = 4'd1,
    CLS_LUI    = 4'd2,
    CLS_AUIPC  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LOAD   = 4'd7,
    CLS_STORE  = 4'd8
  } exec_class_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_EQ   = 4'd10,
    OP_NE   = 4'd11,
    OP_LT   = 4'd12,
    OP_GE   = 4'd13,
    OP_LTU  = 4'd14,
    OP_GEU  = 4'd15
  } alu_fn_e;

  localparam int ALU_OP_IMM_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT_WAIT = 2'd1,
    ST_HOLD       = 2'd2
  } exec_state_e;

endpackage

// File: rtl/cpu_execute_stage_alu.sv
// Combinational integer ALU: arithmetic/logic, set-less-than and branch compares (0/1 result),
// plus a separate shifter output so the execute stage can register it on its own path.
module cpu_execute_stage_alu
  import cpu_execute_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  fn,
  output logic [31:0] result,
  output logic [31:0] shift_result
);

  alu_fn_e     f;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;

  assign f     = alu_fn_e'(fn);
  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Non-shift function codes fall back to a left shift on the shifter output.
  always_comb begin
    shift_result = a << shamt;
    case (f)
      OP_SRL:  shift_result = a >> shamt;
      OP_SRA:  shift_result = $unsigned($signed(a) >>> shamt);
      default: shift_result = a << shamt;
    endcase
  end

  always_comb begin
    result = '0;
    case (f)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL,
      OP_SRL,
      OP_SRA:  result = shift_result;
      OP_SLT:  result = {31'b0, lt_s};
      OP_SLTU: result = {31'b0, lt_u};
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_EQ:   result = {31'b0, a == b};
      OP_NE:   result = {31'b0, a != b};
      OP_LT:   result = {31'b0, lt_s};
      OP_GE:   result = {31'b0, !lt_s};
      OP_LTU:  result = {31'b0, lt_u};
      OP_GEU:  result = {31'b0, !lt_u};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_execute_stage.sv
// Klara-RV execute stage: one ALU, branch/jump resolution, registered writeback/memory/redirect outputs.
// Define CPU_EXECUTE_SHIFT_REG_EN to route shifts through a registered SHIFT_WAIT cycle.
//
// Handshake: an instruction is taken when i_valid && o_ready (and no i_flush); a result is
// handed over when o_valid && i_ready; all outputs hold while o_valid && !i_ready, except the
// one-cycle o_branch / o_misaligned pulses, which appear only in the first o_valid cycle.
module cpu_execute_stage
  import cpu_execute_stage_pkg::*;
#(
  parameter logic ALIGN_CHECK = 1'b1
)
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_class,
  input  logic [4:0]  i_alu_op,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_imm,
  input  logic [4:0]  i_rd,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [4:0]  o_rd,
  output logic        o_rd_write,
  output logic [31:0] o_rd_value,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_branch,
  output logic [31:0] o_branch_target,
  output logic        o_misaligned,
  output logic [1:0]  o_dbg_state
);

  exec_class_e cls;
  exec_state_e state;
  logic [3:0]  alu_fn;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] alu_shift;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] target;
  logic [31:0] result;
  logic        is_ctrl;
  logic        is_mem;
  logic        taken;
  logic        misaligned;
  logic        rd_write;
  logic        accept;
  logic        shift_defer;

  assign cls         = exec_class_e'(i_class);
  assign o_dbg_state = state;

  always_comb begin
    alu_a  = (cls == CLS_AUIPC) ? i_pc : i_rs1;
    alu_b  = i_imm;
    alu_fn = OP_ADD;
    case (cls)
      CLS_ALU, CLS_SHIFT: begin
        alu_fn = i_alu_op[3:0];
        if (!i_alu_op[ALU_OP_IMM_BIT]) alu_b = i_rs2;
      end
      CLS_BRANCH: begin
        alu_fn = i_alu_op[3:0];
        alu_b  = i_rs2;
      end
      default: ;
    endcase
  end

  cpu_execute_stage_alu u_alu (
    .a            (alu_a),
    .b            (alu_b),
    .fn           (alu_fn),
    .result       (alu_result),
    .shift_result (alu_shift)
  );

  // Link address and pc-relative target have their own adders so the ALU is free for compares.
  assign pc_plus4    = i_pc + 32'd4;
  assign pc_plus_imm = i_pc + i_imm;
  assign target      = (cls == CLS_JALR) ? {alu_result[31:1], 1'b0} : pc_plus_imm;
  assign is_ctrl     = (cls == CLS_BRANCH) || (cls == CLS_JAL) || (cls == CLS_JALR);
  assign is_mem      = (cls == CLS_LOAD) || (cls == CLS_STORE);

  always_comb begin
    taken = 1'b0;
    case (cls)
      CLS_BRANCH:       taken = alu_result[0];
      CLS_JAL, CLS_JALR: taken = 1'b1;
      default:          taken = 1'b0;
    endcase
  end

  assign misaligned = taken && ALIGN_CHECK && target[1];
  assign rd_write   = (cls != CLS_BRANCH) && (cls != CLS_STORE) && (i_rd != 5'd0) && !misaligned;

  always_comb begin
    result = '0;
    case (cls)
      CLS_ALU, CLS_AUIPC, CLS_LOAD: result = alu_result;
      CLS_SHIFT:                    result = alu_shift;
      CLS_LUI:                      result = i_imm;
      CLS_JAL, CLS_JALR:            result = pc_plus4;
      default:                      result = '0;
    endcase
  end

`ifdef CPU_EXECUTE_SHIFT_REG_EN
  logic [31:0] shift_q;

  assign o_ready     = (state != ST_SHIFT_WAIT) && (!o_valid || i_ready);
  assign shift_defer = (cls == CLS_SHIFT);

  always_ff @(posedge i_clock) begin
    if (i_reset)     shift_q <= '0;
    else if (accept) shift_q <= alu_shift;
  end
`else
  assign o_ready     = !o_valid || i_ready;
  assign shift_defer = 1'b0;
`endif

  // Flush wins over acceptance even though o_ready itself does not see it.
  assign accept = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= ST_IDLE;
      o_valid         <= 1'b0;
      o_rd            <= '0;
      o_rd_write      <= 1'b0;
      o_rd_value      <= '0;
      o_mem_read      <= 1'b0;
      o_mem_write     <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_wdata     <= '0;
      o_branch        <= 1'b0;
      o_branch_target <= '0;
      o_misaligned    <= 1'b0;
    end else if (i_flush) begin
      state        <= ST_IDLE;
      o_valid      <= 1'b0;
      o_rd_write   <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_branch     <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      o_branch     <= 1'b0;
      o_misaligned <= 1'b0;
      if (accept) begin
        o_rd            <= i_rd;
        o_rd_write      <= rd_write;
        o_rd_value      <= result;
        o_mem_read      <= (cls == CLS_LOAD);
        o_mem_write     <= (cls == CLS_STORE);
        o_mem_addr      <= is_mem ? alu_result : 32'd0;
        o_mem_wdata     <= (cls == CLS_STORE) ? i_rs2 : 32'd0;
        o_branch_target <= is_ctrl ? target : 32'd0;
        if (shift_defer) begin
          state   <= ST_SHIFT_WAIT;
          o_valid <= 1'b0;
        end else begin
          state        <= ST_HOLD;
          o_valid      <= 1'b1;
          o_branch     <= taken && !misaligned;
          o_misaligned <= misaligned;
        end
      end
`ifdef CPU_EXECUTE_SHIFT_REG_EN
      else if (state == ST_SHIFT_WAIT) begin
        state      <= ST_HOLD;
        o_valid    <= 1'b1;
        o_rd_value <= shift_q;
      end
`endif
      else if (o_valid && i_ready) begin
        state   <= ST_IDLE;
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_execute_stage.sv
// Bench for cpu_execute_stage: reset checks, directed vector table, handshake corner sequences,
// and randomized instructions scored against an arithmetic reference model.
module tb_cpu_execute_stage;
  import cpu_execute_stage_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready;
  logic [3:0]  i_class;
  logic [4:0]  i_alu_op, i_rd;
  logic [31:0] i_pc, i_rs1, i_rs2, i_imm;
  logic        o_ready, o_valid, o_rd_write, o_mem_read, o_mem_write, o_branch, o_misaligned;
  logic [4:0]  o_rd;
  logic [31:0] o_rd_value, o_mem_addr, o_mem_wdata, o_branch_target;
  logic [1:0]  o_dbg_state;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  op;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
  } txn_t;

  typedef struct packed {
    logic        wr, chk, br, mis, mr, mw;
    logic [4:0]  rd;
    logic [31:0] value, tgt, addr, wdata;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic shift_reg_mode;

  cpu_execute_stage #(.ALIGN_CHECK(1'b1)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_class(i_class), .i_alu_op(i_alu_op), .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_imm(i_imm), .i_rd(i_rd), .o_valid(o_valid), .i_ready(i_ready), .o_rd(o_rd),
    .o_rd_write(o_rd_write), .o_rd_value(o_rd_value), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_branch(o_branch), .o_branch_target(o_branch_target), .o_misaligned(o_misaligned),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clock = ~i_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return (a == b) ? 32'd1 : 32'd0;
      4'd11: return (a != b) ? 32'd1 : 32'd0;
      4'd12: return (sa < sb) ? 32'd1 : 32'd0;
      4'd13: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd14: return (a < b) ? 32'd1 : 32'd0;
      default: return (a >= b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input txn_t t);
    exp_t e;
    logic [31:0] b, tgt, cmp;
    logic taken;
    e = '0;
    tgt = '0;
    taken = 1'b0;
    b = t.op[4] ? t.imm : t.rs2;
    e.rd = t.rd;
    case (t.cls)
      CLS_ALU, CLS_SHIFT: e.value = alu_ref(t.op[3:0], t.rs1, b);
      CLS_LUI:   e.value = t.imm;
      CLS_AUIPC: e.value = t.pc + t.imm;
      CLS_JAL: begin e.value = t.pc + 32'd4; tgt = t.pc + t.imm; taken = 1'b1; end
      CLS_JALR: begin e.value = t.pc + 32'd4; tgt = (t.rs1 + t.imm) & 32'hFFFF_FFFE; taken = 1'b1; end
      CLS_LOAD: begin e.mr = 1'b1; e.addr = t.rs1 + t.imm; end
      CLS_STORE: begin e.mw = 1'b1; e.addr = t.rs1 + t.imm; e.wdata = t.rs2; end
      CLS_BRANCH: begin
        cmp = alu_ref(t.op[3:0], t.rs1, t.rs2);
        taken = cmp[0];
        tgt = t.pc + t.imm;
      end
      default: ;
    endcase
    e.tgt = tgt;
    e.mis = taken && tgt[1];
    e.br  = taken && !e.mis;
    e.wr  = (t.cls != CLS_BRANCH) && (t.cls != CLS_STORE) && (t.rd != 5'd0) && !e.mis;
    e.chk = e.wr && (t.cls != CLS_LOAD);
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] cls, input logic [4:0] op, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [4:0] rd, input logic wr, input logic chk, input logic [31:0] val,
                              input logic br, input logic mis, input logic [31:0] tgt, input logic mr,
                              input logic mw, input logic [31:0] addr, input logic [31:0] wdata);
    vec_t v;
    v.t = '{cls: cls, op: op, pc: pc, rs1: rs1, rs2: rs2, imm: imm, rd: rd};
    v.e = '{wr: wr, chk: chk, br: br, mis: mis, mr: mr, mw: mw, rd: rd,
            value: val, tgt: tgt, addr: addr, wdata: wdata};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input txn_t t);
    i_class = t.cls; i_alu_op = t.op; i_pc = t.pc;
    i_rs1 = t.rs1; i_rs2 = t.rs2; i_imm = t.imm; i_rd = t.rd;
  endtask

  task automatic send(input txn_t t, output int waits);
    waits = 0;
    @(negedge i_clock);
    drive(t);
    i_valid = 1'b1;
    while (!o_ready && waits < 50) begin
      @(negedge i_clock);
      waits++;
    end
    if (waits >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: got o_ready=0 for %0d cycles, required acceptance", waits);
    end
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge i_clock);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    @(posedge i_clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge i_clock) begin
    if (mon_en && !i_reset && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got o_valid=1, required no result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_write", 32'(o_rd_write), 32'(e.wr));
        check("branch", 32'(o_branch), 32'(e.br));
        check("misaligned", 32'(o_misaligned), 32'(e.mis));
        check("mem_read", 32'(o_mem_read), 32'(e.mr));
        check("mem_write", 32'(o_mem_write), 32'(e.mw));
        if (e.wr) check("rd", 32'(o_rd), 32'(e.rd));
        if (e.chk) check("rd_value", o_rd_value, e.value);
        if (e.br || e.mis) check("branch_target", o_branch_target, e.tgt);
        if (e.mr || e.mw) check("mem_addr", o_mem_addr, e.addr);
        if (e.mw) check("mem_wdata", o_mem_wdata, e.wdata);
      end
    end
  end

  // ---------------- test sequence ----------------
  vec_t vecs[16];

  initial begin
    int w, wsum;
    txn_t t;
`ifdef CPU_EXECUTE_SHIFT_REG_EN
    shift_reg_mode = 1'b1;
`else
    shift_reg_mode = 1'b0;
`endif
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    drive('0);

    vecs[0]  = mk(CLS_ALU,    5'h10, 32'h0, 32'd5, 32'd0, 32'd7, 5'd3, 1, 1, 32'd12, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(CLS_BRANCH, 5'd10, 32'h100, 32'd9, 32'd9, 32'h20, 5'd0, 0, 0, 0, 1, 0, 32'h120, 0, 0, 0, 0);
    vecs[2]  = mk(CLS_BRANCH, 5'd10, 32'h100, 32'd9, 32'd8, 32'h20, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(CLS_JALR,   5'd0, 32'h200, 32'h1001, 32'd0, 32'd1, 5'd1, 0, 0, 0, 0, 1, 32'h1002, 0, 0, 0, 0);
    vecs[4]  = mk(CLS_JAL,    5'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 5'd1, 1, 1, 32'd0, 1, 0, 32'd4, 0, 0, 0, 0);
    vecs[5]  = mk(CLS_SHIFT,  5'd2, 32'h0, 32'd1, 32'd31, 32'd0, 5'd5, 1, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(CLS_SHIFT,  5'h17, 32'h0, 32'h8000_0000, 32'd0, 32'd4, 5'd6, 1, 1, 32'hF800_0000, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(CLS_STORE,  5'd0, 32'h0, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFC, 32'hDEAD_BEEF);
    vecs[8]  = mk(CLS_LOAD,   5'd0, 32'h0, 32'h2000, 32'd0, 32'h10, 5'd7, 1, 0, 0, 0, 0, 0, 1, 0, 32'h2010, 0);
    vecs[9]  = mk(CLS_LUI,    5'd0, 32'h0, 32'd0, 32'd0, 32'h1234_5000, 5'd8, 1, 1, 32'h1234_5000, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(CLS_AUIPC,  5'd0, 32'h400, 32'd0, 32'd0, 32'h1000, 5'd9, 1, 1, 32'h1400, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(CLS_ALU,    5'd1, 32'h0, 32'd3, 32'd5, 32'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(CLS_ALU,    5'd3, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd10, 1, 1, 32'd1, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(CLS_BRANCH, 5'd13, 32'h500, 32'd5, 32'hFFFF_FFFD, 32'h40, 5'd0, 0, 0, 0, 1, 0, 32'h540, 0, 0, 0, 0);
    vecs[14] = mk(CLS_BRANCH, 5'd11, 32'h600, 32'd1, 32'd2, 32'd6, 5'd0, 0, 0, 0, 0, 1, 32'h606, 0, 0, 0, 0);
    vecs[15] = mk(CLS_JAL,    5'd0, 32'h10, 32'd0, 32'd0, 32'h10, 5'd0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 0);

    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_branch", 32'(o_branch), 32'd0);
    check("reset_misaligned", 32'(o_misaligned), 32'd0);
    check("reset_rd_write", 32'(o_rd_write), 32'd0);
    check("reset_rd_value", o_rd_value, 32'd0);
    check("reset_mem", {30'd0, o_mem_read, o_mem_write}, 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'(ST_IDLE));

    // directed vectors through the scoreboard
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(vecs[i].e);
      send(vecs[i].t, w);
    end
    drain();

    // back-to-back adds accept every cycle
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      t = '{cls: CLS_ALU, op: 5'h10, pc: 32'h0, rs1: 32'(i * 3), rs2: 32'd0, imm: 32'd7, rd: 5'd3};
      exp_q.push_back(model(t));
      send(t, w);
      wsum += w;
    end
    check("back_to_back_waits", 32'(wsum), 32'd0);
    drain();

    // randomized instructions against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [31:0] r;
      r = $urandom;
      t.cls = 4'($urandom_range(0, 8));
      t.rd  = 5'($urandom_range(0, 31));
      t.rs1 = $urandom;
      t.rs2 = ($urandom_range(0, 3) == 0) ? t.rs1 : $urandom;
      t.pc  = $urandom & 32'hFFFF_FFFC;
      t.imm = ($urandom_range(0, 3) == 0) ? $urandom : {{20{r[11]}}, r[11:0]};
      case (t.cls)
        CLS_SHIFT:  t.op = {1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 4'd2 :
                            (($urandom_range(0, 1) == 0) ? 4'd6 : 4'd7)};
        CLS_BRANCH: t.op = {1'b0, 4'($urandom_range(10, 15))};
        default:    t.op = 5'($urandom_range(0, 31));
      endcase
      exp_q.push_back(model(t));
      send(t, w);
    end
    drain();
    mon_en = 1'b0;

    // latency: ADD one cycle, shift one or two cycles
    @(negedge i_clock);
    drive(vecs[0].t); i_valid = 1'b1;
    @(posedge i_clock); #1; i_valid = 1'b0;
    check("add_latency_valid", 32'(o_valid), 32'd1);
    check("add_latency_value", o_rd_value, 32'd12);
    @(negedge i_clock);
    drive(vecs[5].t); i_valid = 1'b1;
    @(posedge i_clock); #1; i_valid = 1'b0;
    if (shift_reg_mode) begin
      check("shift_wait_ready", 32'(o_ready), 32'd0);
      check("shift_wait_valid", 32'(o_valid), 32'd0);
      @(posedge i_clock); #1;
    end
    check("shift_latency_valid", 32'(o_valid), 32'd1);
    check("shift_latency_value", o_rd_value, 32'h8000_0000);
    @(posedge i_clock); #1;

    // store held for three cycles while decode keeps offering an add
    @(negedge i_clock);
    t = '{cls: CLS_STORE, op: 5'd0, pc: 32'h0, rs1: 32'h3000, rs2: 32'h55AA, imm: 32'h24, rd: 5'd0};
    drive(t); i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clock); #1;
    drive(vecs[0].t);
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_ready", 32'(o_ready), 32'd0);
      check("hold_mem_addr", o_mem_addr, 32'h3024);
      check("hold_mem_wdata", o_mem_wdata, 32'h55AA);
      check("hold_mem_write", 32'(o_mem_write), 32'd1);
      @(posedge i_clock); #1;
    end
    i_ready = 1'b1;
    @(posedge i_clock); #1; i_valid = 1'b0;
    check("release_next_value", o_rd_value, 32'd12);
    check("release_next_mem_write", 32'(o_mem_write), 32'd0);
    @(posedge i_clock); #1;

    // branch pulse not repeated while held
    @(negedge i_clock);
    t = '{cls: CLS_JAL, op: 5'd0, pc: 32'h100, rs1: 32'd0, rs2: 32'd0, imm: 32'h40, rd: 5'd1};
    drive(t); i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clock); #1; i_valid = 1'b0;
    check("pulse_first_branch", 32'(o_branch), 32'd1);
    check("pulse_first_target", o_branch_target, 32'h140);
    @(posedge i_clock); #1;
    check("pulse_held_branch", 32'(o_branch), 32'd0);
    check("pulse_held_valid", 32'(o_valid), 32'd1);
    check("pulse_held_value", o_rd_value, 32'h104);
    i_ready = 1'b1;
    @(posedge i_clock); #1;

    // flush with a valid input while holding
    @(negedge i_clock);
    drive(vecs[0].t); i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clock); #1;
    t = '{cls: CLS_ALU, op: 5'h10, pc: 32'h0, rs1: 32'd1, rs2: 32'd0, imm: 32'd1, rd: 5'd4};
    drive(t); i_flush = 1'b1;
    @(posedge i_clock); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_state", 32'(o_dbg_state), 32'(ST_IDLE));
    check("flush_ready", 32'(o_ready), 32'd1);
    @(posedge i_clock); #1;
    check("flush_no_accept", 32'(o_valid), 32'd0);
    i_ready = 1'b1;

    // reset right after a shift is accepted
    @(negedge i_clock);
    drive(vecs[5].t); i_valid = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0; i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    check("reset_shift_valid", 32'(o_valid), 32'd0);
    check("reset_shift_ready", 32'(o_ready), 32'd1);
    check("reset_shift_value", o_rd_value, 32'd0);
    @(posedge i_clock); #1;
    check("reset_shift_after", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
